pass_change_ctrl: RTL and testbench
===================================

# pass_change_ctrl

Password-update controller for the binary game's authentication path. It writes a logged-in user's new 4-digit password into the password RAM, the same storage that the login controller reads nibble by nibble. The user enters the new password twice through the existing digit switches and enter button. The block writes the four nibbles only if both entries match, and it reports Done, Mismatch or Abort to the game controller.

## Interface
Parameters:
- DIGITS, 4: nibbles per password; also the number of RAM words written per user.
- MAX_TRIES, 3: confirm mismatches allowed before the request is abandoned.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- LogIn  in  1  high while a user is authenticated.
- GMLogOut  in  1  logout request from the game controller.
- Change_Req  in  1  single-cycle request to start a password change.
- Game_Enter  in  1  single-cycle pulse; the enter button is debounced and one-shotted upstream.
- User_digit  in  4  digit value presented when Game_Enter pulses.
- Internal_ID  in  5  RAM base address of the user's password; bits [1:0] are ignored and treated as 00.
- ram_addr  out  5  password RAM write address.
- ram_data  out  4  password RAM write nibble.
- ram_wren  out  1  RAM write enable; one nibble is written per cycle while high.
- Busy  out  1  high whenever the state is not IDLE.
- Done  out  1  one-cycle pulse when all four nibbles have been written.
- Mismatch  out  1  one-cycle pulse when the confirm entry differs from the new entry.
- Abort  out  1  one-cycle pulse when the change is abandoned.

## Operation
- Internal registers:
  - NewPass[15:0], ConfPass[15:0]: captured entries.
  - DigitCnt[1:0]: digits received in the current entry.
  - TryCnt[1:0]: confirm mismatches so far.
  - WrCnt[1:0]: nibbles written.
  - Base[4:0]: latched RAM base address.
- Digit packing: on each Game_Enter, reg <= (reg << 4) | User_digit. The first digit entered ends up in bits [15:12].
- States and transitions:
  - IDLE: when Change_Req && LogIn, latch Base = {Internal_ID[4:2],2'b00}, clear all counters, go to ENTER_NEW. Otherwise stay.
  - ENTER_NEW: capture a digit on each Game_Enter. On the 4th digit, clear DigitCnt and go to ENTER_CONF.
  - ENTER_CONF: capture into ConfPass the same way. On the 4th digit go to COMPARE.
  - COMPARE (1 cycle):
    - Equal: go to WRITE with WrCnt=0.
    - Unequal, TryCnt+1 < MAX_TRIES: pulse Mismatch, increment TryCnt, clear NewPass, ConfPass and DigitCnt, go to ENTER_NEW.
    - Unequal, TryCnt+1 == MAX_TRIES: pulse both Mismatch and Abort, go to IDLE.
  - WRITE (4 cycles):
    - ram_wren=1, ram_addr=Base+WrCnt.
    - ram_data = NewPass[15:12], [11:8], [7:4], [3:0] for WrCnt = 0..3.
    - After WrCnt==3, go to DONE.
  - DONE (1 cycle): pulse Done, go to IDLE.
- Abort conditions in ENTER_NEW, ENTER_CONF and COMPARE: GMLogOut==1 or LogIn==0 gives an Abort pulse next cycle and a return to IDLE. No RAM write occurs. Abort has priority over a Game_Enter in the same cycle.
- WRITE and DONE are uninterruptible. GMLogOut, LogIn and Change_Req are ignored there, so no partial password results except from rst.
- Ignored inputs:
  - Change_Req while Busy.
  - Change_Req in IDLE while LogIn==0.
  - Game_Enter in IDLE, COMPARE, WRITE and DONE.
- ram_addr and ram_data hold their last value when ram_wren==0. Only ram_wren qualifies them.

## Timing
- Reset: rst high at an edge sets state IDLE and clears all registers. ram_addr, ram_data, ram_wren, Busy, Done, Mismatch and Abort are all 0 from the following cycle.
- Reset during WRITE: ram_wren drops the next cycle. Nibbles already written stay in RAM.
- All outputs are registered.
  - Busy rises the cycle after the accepted Change_Req.
  - Mismatch and Abort assert the cycle after the deciding edge, for exactly 1 cycle.
- Latency: the edge with the 8th Game_Enter leads to COMPARE next cycle. ram_wren is high on the following 4 cycles, then Done for 1 cycle, then Busy falls. That is 6 cycles from the last digit to Busy low.
- Back-to-back Game_Enter on consecutive cycles is legal; each pulse captures one digit.
- The address never wraps out of the user's 4-word block: Base+3 ≤ 31 always.

## Test plan
- Internal_ID=5'd8, Change_Req, digits 1,2,3,4 then 1,2,3,4: ram_wren high 4 cycles, writing addr 8,9,10,11 with data 1,2,3,4; Done 1 cycle; Busy low 6 cycles after the 8th enter.
- Internal_ID=5'd6, new 9,0,9,0, confirm 9,0,9,1: one Mismatch pulse, no write. Then re-enter 9,0,9,0 twice: writes go to addr 4..7.
- Three consecutive confirm mismatches: the 3rd COMPARE pulses Mismatch and Abort together, Busy drops, no ram_wren ever.
- GMLogOut during ENTER_CONF after 2 digits: Abort next cycle, IDLE, no write. GMLogOut asserted during WRITE: all 4 writes and Done still complete.
- Change_Req with LogIn=0: stays IDLE, Busy=0. Change_Req while in ENTER_NEW: ignored, with DigitCnt and TryCnt unchanged.
- rst high after the 2nd write cycle: ram_wren 0 and Busy 0 next cycle, no Done. A fresh Change_Req then works normally.

Source files
------------

// File: rtl/pass_change_ctrl_if.sv
// Handshake bundle between the game controller / digit entry path and the
// password-change controller, including the password RAM write port.
interface pass_change_ctrl_if;
  logic       LogIn;
  logic       GMLogOut;
  logic       Change_Req;
  logic       Game_Enter;
  logic [3:0] User_digit;
  logic [4:0] Internal_ID;
  logic [4:0] ram_addr;
  logic [3:0] ram_data;
  logic       ram_wren;
  logic       Busy;
  logic       Done;
  logic       Mismatch;
  logic       Abort;

  modport master (
    output LogIn, GMLogOut, Change_Req, Game_Enter, User_digit, Internal_ID,
    input  ram_addr, ram_data, ram_wren, Busy, Done, Mismatch, Abort
  );

  modport slave (
    input  LogIn, GMLogOut, Change_Req, Game_Enter, User_digit, Internal_ID,
    output ram_addr, ram_data, ram_wren, Busy, Done, Mismatch, Abort
  );
endinterface

// File: rtl/pass_change_ctrl.sv
// Password-update controller: collects a new password twice, compares the two
// entries and writes the nibbles into the password RAM when they match.
module pass_change_ctrl #(
  parameter int DIGITS    = 4,
  parameter int MAX_TRIES = 3
) (
  input  logic               clk,
  input  logic               rst,
  pass_change_ctrl_if.slave  bus
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam int PW = 4 * DIGITS;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [2:0] {
    IDLE, ENTER_NEW, ENTER_CONF, COMPARE, WRITE, DONE
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   new_pass, conf_pass;
  logic [CW-1:0]   digit_cnt, wr_cnt, wr_idx;
  logic [TW-1:0]   try_cnt;
  logic [4:0]      base;

  logic abort_req, start, last_digit, pass_eq, last_try;
  logic busy_d, wren_d, done_d, mismatch_d, abort_d;
  logic [4:0] addr_d;
  logic [3:0] data_d;

  // First digit entered sits in the most significant nibble.
  function automatic logic [3:0] nibble(input logic [PW-1:0] p, input logic [CW-1:0] idx);
    return p[PW - 4 - 4 * int'(idx) +: 4];
  endfunction

  assign abort_req  = bus.GMLogOut || !bus.LogIn;
  assign start      = bus.Change_Req && bus.LogIn;
  assign last_digit = bus.Game_Enter && (digit_cnt == LAST);
  assign pass_eq    = (new_pass == conf_pass);
  assign last_try   = (int'(try_cnt) + 1) >= MAX_TRIES;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (start) state_n = ENTER_NEW;
      ENTER_NEW:  if (abort_req) state_n = IDLE;
                  else if (last_digit) state_n = ENTER_CONF;
      ENTER_CONF: if (abort_req) state_n = IDLE;
                  else if (last_digit) state_n = COMPARE;
      COMPARE:    if (abort_req) state_n = IDLE;
                  else if (pass_eq) state_n = WRITE;
                  else if (last_try) state_n = IDLE;
                  else state_n = ENTER_NEW;
      WRITE:      if (wr_cnt == LAST) state_n = DONE;
      DONE:       state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered copies line up with it.
  always_comb begin
    wr_idx     = (state == WRITE) ? wr_cnt + CW'(1) : '0;
    busy_d     = (state_n != IDLE);
    wren_d     = (state_n == WRITE);
    done_d     = (state_n == DONE);
    mismatch_d = (state == COMPARE) && !abort_req && !pass_eq;
    abort_d    = ((state == ENTER_NEW || state == ENTER_CONF || state == COMPARE) && abort_req)
                 || (mismatch_d && last_try);
    addr_d     = base + 5'(wr_idx);
    data_d     = nibble(new_pass, wr_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ram_addr <= '0;
      bus.ram_data <= '0;
      bus.ram_wren <= 1'b0;
      bus.Busy     <= 1'b0;
      bus.Done     <= 1'b0;
      bus.Mismatch <= 1'b0;
      bus.Abort    <= 1'b0;
    end else begin
      bus.ram_wren <= wren_d;
      bus.Busy     <= busy_d;
      bus.Done     <= done_d;
      bus.Mismatch <= mismatch_d;
      bus.Abort    <= abort_d;
      if (wren_d) begin
        bus.ram_addr <= addr_d;
        bus.ram_data <= data_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      new_pass  <= '0;
      conf_pass <= '0;
      digit_cnt <= '0;
      try_cnt   <= '0;
      wr_cnt    <= '0;
      base      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          base      <= {bus.Internal_ID[4:2], 2'b00};
          new_pass  <= '0;
          conf_pass <= '0;
          digit_cnt <= '0;
          try_cnt   <= '0;
          wr_cnt    <= '0;
        end
        ENTER_NEW: if (!abort_req && bus.Game_Enter) begin
          new_pass  <= {new_pass[PW-5:0], bus.User_digit};
          digit_cnt <= last_digit ? '0 : digit_cnt + CW'(1);
        end
        ENTER_CONF: if (!abort_req && bus.Game_Enter) begin
          conf_pass <= {conf_pass[PW-5:0], bus.User_digit};
          digit_cnt <= last_digit ? '0 : digit_cnt + CW'(1);
        end
        COMPARE: if (!abort_req) begin
          if (pass_eq) begin
            wr_cnt <= '0;
          end else if (!last_try) begin
            try_cnt   <= try_cnt + TW'(1);
            new_pass  <= '0;
            conf_pass <= '0;
            digit_cnt <= '0;
          end
        end
        WRITE:   wr_cnt <= wr_cnt + CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pass_change_ctrl.sv
// Self-checking bench for pass_change_ctrl: directed and randomized password
// change sessions compared against a transaction-level model of the RAM.
module tb_pass_change_ctrl;
  localparam int MAX_TRIES = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pass_change_ctrl_if bus ();

  pass_change_ctrl #(.DIGITS(4), .MAX_TRIES(MAX_TRIES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int mon_wr = 0, mon_done = 0, mon_mm = 0, mon_ab = 0;
  bit [3:0] mem_obs [32];
  bit [3:0] mem_exp [32];

  logic [15:0] att_new  [MAX_TRIES];
  logic [15:0] att_conf [MAX_TRIES];
  int creq_att  = -1;
  bit logout_wr = 1'b0;

  // Observed RAM and pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.ram_wren) begin
      mem_obs[bus.ram_addr] <= bus.ram_data;
      mon_wr <= mon_wr + 1;
    end
    if (bus.Done)     mon_done <= mon_done + 1;
    if (bus.Mismatch) mon_mm   <= mon_mm + 1;
    if (bus.Abort)    mon_ab   <= mon_ab + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic enter_digit(input logic [3:0] d);
    repeat ($urandom_range(0, 2)) tick();
    bus.Game_Enter = 1'b1;
    bus.User_digit = d;
    tick();
    bus.Game_Enter = 1'b0;
    bus.User_digit = 4'($urandom);
  endtask

  task automatic enter_word(input logic [15:0] w, input bit creq_mid);
    for (int i = 0; i < 4; i++) begin
      enter_digit(w[15 - 4*i -: 4]);
      if (creq_mid && i == 1) begin
        bus.Change_Req = 1'b1;
        tick();
        bus.Change_Req = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && bus.Busy; i++) tick();
    check("idle_timeout", bus.Busy, 1'b0);
  endtask

  task automatic check_mem(input string tag);
    int d = 0;
    tick();
    for (int a = 0; a < 32; a++) if (mem_obs[a] !== mem_exp[a]) d++;
    check(tag, d, 0);
  endtask

  // Outcome of a session from the rules alone: first equal pair is written,
  // MAX_TRIES unequal pairs abandon the request.
  task automatic model(input int n, input logic [4:0] base,
                       output int mm, output int ab, output int dn, output int wr);
    mm = 0; ab = 0; dn = 0; wr = 0;
    for (int k = 0; k < n; k++) begin
      if (att_new[k] == att_conf[k]) begin
        dn = 1; wr = 4;
        for (int j = 0; j < 4; j++)
          mem_exp[int'(base) + j] = 4'(att_new[k] >> (4 * (3 - j)));
        break;
      end
      mm++;
      if (mm == MAX_TRIES) begin
        ab = 1;
        break;
      end
    end
  endtask

  task automatic make_attempts(input bit force_fail, output int n);
    bit match;
    n = 0;
    for (int k = 0; k < MAX_TRIES; k++) begin
      att_new[k]  = 16'($urandom);
      match       = !force_fail && ($urandom_range(0, 2) == 0);
      att_conf[k] = match ? att_new[k] : att_new[k] ^ 16'($urandom_range(1, 65535));
      n = k + 1;
      if (match) break;
    end
  endtask

  task automatic run_session(input logic [4:0] id, input int n);
    int mm, ab, dn, wr, w0, d0, m0, a0;
    logic [4:0] base;
    bit last;
    base = {id[4:2], 2'b00};
    model(n, base, mm, ab, dn, wr);
    w0 = mon_wr; d0 = mon_done; m0 = mon_mm; a0 = mon_ab;
    bus.Internal_ID = id;
    bus.Change_Req  = 1'b1;
    tick();
    bus.Change_Req  = 1'b0;
    bus.Internal_ID = 5'($urandom);
    check("busy_rise", bus.Busy, 1'b1);
    for (int k = 0; k < n; k++) begin
      enter_word(att_new[k], creq_att == k);
      enter_word(att_conf[k], 1'b0);
      check("compare_cycle", {bus.ram_wren, bus.Mismatch, bus.Abort, bus.Busy}, 4'b0001);
      tick();
      if (att_new[k] == att_conf[k]) begin
        if (logout_wr) begin
          bus.GMLogOut = 1'b1;
          bus.LogIn    = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
          check("write", {bus.ram_wren, bus.ram_addr, bus.ram_data},
                {1'b1, 5'(base + 5'(i)), att_new[k][15 - 4*i -: 4]});
          tick();
        end
        check("done", {bus.Done, bus.ram_wren, bus.Busy}, 3'b101);
        tick();
        check("busy_fall", {bus.Busy, bus.Done}, 2'b00);
        bus.GMLogOut = 1'b0;
        bus.LogIn    = 1'b1;
      end else begin
        last = (k + 1 == MAX_TRIES);
        check("mismatch", {bus.Mismatch, bus.Abort, bus.Busy}, {1'b1, last, !last});
        tick();
        check("pulse_end", {bus.Mismatch, bus.Abort}, 2'b00);
      end
    end
    wait_idle(20);
    check_mem("ram_contents");
    check("write_count", mon_wr - w0, wr);
    check("done_count",  mon_done - d0, dn);
    check("mm_count",    mon_mm - m0, mm);
    check("abort_count", mon_ab - a0, ab);
  endtask

  initial begin
    int n, w0, a0, d0;
    rst = 1'b1;
    bus.LogIn = 1'b1; bus.GMLogOut = 1'b0; bus.Change_Req = 1'b0;
    bus.Game_Enter = 1'b0; bus.User_digit = 4'd0; bus.Internal_ID = 5'd0;
    tick(); tick();
    rst = 1'b0;
    check("reset_outputs", {bus.ram_addr, bus.ram_data, bus.ram_wren, bus.Busy,
                            bus.Done, bus.Mismatch, bus.Abort}, 0);

    // Plain match at base 8.
    att_new[0] = 16'h1234; att_conf[0] = 16'h1234;
    run_session(5'd8, 1);

    // One mismatch then a match; low ID bits are ignored.
    att_new[0] = 16'h9090; att_conf[0] = 16'h9091;
    att_new[1] = 16'h9090; att_conf[1] = 16'h9090;
    run_session(5'd6, 2);

    // Three mismatches with a stray Change_Req mid-entry on the second try.
    make_attempts(1'b1, n);
    creq_att = 1;
    run_session(5'($urandom), n);
    creq_att = -1;

    // Logout during WRITE must not interrupt the write burst.
    att_new[0] = 16'($urandom); att_conf[0] = att_new[0];
    logout_wr = 1'b1;
    run_session(5'd28, 1);
    logout_wr = 1'b0;

    // Logout during confirm entry after two digits, coinciding with an enter.
    w0 = mon_wr; a0 = mon_ab;
    bus.Internal_ID = 5'd12; bus.Change_Req = 1'b1; tick(); bus.Change_Req = 1'b0;
    enter_word(16'h4321, 1'b0);
    enter_digit(4'd4); enter_digit(4'd3);
    bus.GMLogOut = 1'b1; bus.Game_Enter = 1'b1; bus.User_digit = 4'd2;
    tick();
    bus.GMLogOut = 1'b0; bus.Game_Enter = 1'b0;
    check("logout_abort", {bus.Abort, bus.Busy, bus.Mismatch}, 3'b100);
    tick();
    check("logout_abort_end", bus.Abort, 1'b0);
    tick();
    check("logout_no_write", mon_wr - w0, 0);
    check("logout_abort_count", mon_ab - a0, 1);

    // Change_Req while logged out is ignored.
    bus.LogIn = 1'b0; bus.Change_Req = 1'b1; tick(); bus.Change_Req = 1'b0;
    check("req_logged_out", bus.Busy, 1'b0);
    tick();
    check("req_logged_out_hold", bus.Busy, 1'b0);
    bus.LogIn = 1'b1;

    // Reset after the second write cycle.
    d0 = mon_done;
    bus.Internal_ID = 5'd20; bus.Change_Req = 1'b1; tick(); bus.Change_Req = 1'b0;
    enter_word(16'hABCD, 1'b0);
    enter_word(16'hABCD, 1'b0);
    tick();
    check("rst_write0", {bus.ram_wren, bus.ram_addr, bus.ram_data}, {1'b1, 5'd20, 4'hA});
    tick();
    check("rst_write1", {bus.ram_wren, bus.ram_addr, bus.ram_data}, {1'b1, 5'd21, 4'hB});
    mem_exp[20] = 4'hA; mem_exp[21] = 4'hB;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_outputs", {bus.ram_addr, bus.ram_data, bus.ram_wren, bus.Busy,
                          bus.Done, bus.Mismatch, bus.Abort}, 0);
    tick();
    check("rst_no_done", {bus.Done, bus.Busy}, 2'b00);
    check("rst_done_count", mon_done - d0, 0);
    check_mem("rst_partial_ram");

    att_new[0] = 16'h5E6F; att_conf[0] = 16'h5E6F;
    run_session(5'd21, 1);

    for (int s = 0; s < 8; s++) begin
      make_attempts(1'b0, n);
      run_session(5'($urandom), n);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
